score_keeper: RTL and testbench
===============================

# score_keeper

Downstream consumer of the game controller's `add_point`, `pause`, `reset_game`, `crash_en` and `finish_en` outputs.
- Counts coins as a 4-digit BCD score.
- Times each run in tenths of a second.
- Optionally tracks a high score.
- Drives the board's 4-digit multiplexed seven-segment display.

## Interface
Parameters:
- `CLK_HZ`, 100_000_000, clk frequency; tenth-second tick period is `CLK_HZ/10` cycles.
- `REFRESH_DIV`, 100_000, clk cycles each display digit is lit.
- `FINISH_BONUS`, 5, binary points added once on finish (0–99).

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high reset
- `add_point`  in  1  controller coin flag; counts once per rising edge
- `reset_game`  in  1  controller start-page flag; clears the run
- `pause`  in  1  controller pause flag
- `crash_en`  in  1  controller crash flag
- `finish_en`  in  1  controller finish flag
- `show_time`  in  1  1 = display run timer, 0 = display score
- `show_hi`  in  1  1 = display high score (overrides `show_time`; macro only)
- `score`  out  16  BCD score, 4 digits
- `run_time`  out  16  BCD timer, tenths of a second (`999.9` max)
- `hiscore`  out  16  BCD high score
- `new_record`  out  1  one-cycle pulse on a high-score update
- `an`  out  4  digit enables, active-low one-hot
- `seg`  out  7  segments {g..a}, active-low
- `dp`  out  1  decimal point, active-low

## Operation
State machine, 2-bit: IDLE, RUN, HOLD.
- IDLE:
  - Score, timer and prescaler are held at 0.
  - Go to RUN when `reset_game=0` and `pause=0`.
- RUN:
  - Rising edge of `add_point` (`add_point & ~add_point_q`) adds 1 to the BCD score.
  - The prescaler counts while `pause=0`. Each wrap at `CLK_HZ/10-1` adds 1 to the timer.
  - Rising edge of `crash_en` or `finish_en` goes to HOLD.
  - `reset_game=1` goes to IDLE.
- HOLD:
  - Score and timer are frozen.
  - The cycle HOLD is entered via `finish_en`, `FINISH_BONUS` is added (saturating).
  - `reset_game=1` goes to IDLE.
- BCD arithmetic is per-digit with carry. Score saturates at `9999` and the timer at `9999`; neither wraps.
- A coin edge and a crash/finish edge in the same cycle: the point counts, then the block enters HOLD.
- If both `crash_en` and `finish_en` rise in the same cycle, it is treated as a finish.
- Edge detectors (`add_point_q`, `crash_q`, `finish_q`) update in every state, so a level already high on entering RUN is not counted.
- Display:
  - The refresh counter steps the digit index 0→3 and wraps.
  - `an` is active-low one-hot, digit 0 = rightmost.
  - `seg` is decoded from the selected nibble. `dp=0` only on digit 1 while the timer is shown.

## Timing
- Reset values:
  - state IDLE
  - `score`, `run_time`, `hiscore` = 0
  - `new_record` = 0
  - `an=4'b1111`, `seg=7'h7F`, `dp=1`
  - all counters = 0
- Reset mid-run aborts immediately with the values above. The high score is also cleared.
- `score` changes on the first clk edge where the edge condition holds, i.e. it is visible one cycle after `add_point` first reads 1.
- Timer increment is registered: `run_time` changes the cycle after the prescaler wrap.
- IDLE→RUN and RUN→HOLD each take one edge after the qualifying input.
- `reset_game=1` in any state forces IDLE on the next edge and clears the score that edge.
- Display outputs are registered, so `an`/`seg` lag the digit index by one cycle.

## Configuration
- `SCORE_KEEPER_HISCORE_EN` defined:
  - On the HOLD-entry cycle via finish, if the final score (bonus included) is greater than `hiscore`, `hiscore` is updated the next edge and `new_record` pulses one cycle.
  - Crash never updates `hiscore`.
  - `reset_game` does not clear `hiscore`.
  - `show_hi` selects the high score on the display.
- Undefined: `hiscore=0` and `new_record=0` are constant, `show_hi` is ignored, and the comparator and register are absent.

## Test plan
Simulation parameters: `CLK_HZ=100` (10-cycle tick), `REFRESH_DIV=4`.
- Reset, drop `reset_game`/`pause`, hold `add_point` high 50 cycles → `score=0x0001` (single count per edge).
- Enter RUN, 3 pulses of `add_point` during `pause=1` for 25 cycles, then run 40 cycles → `score=0x0003`, `run_time=0x0004`; the paused cycles add no time.
- Preload to `9998`, then 3 coin edges → `score=0x9999` (saturates, no wrap).
- Score 7, assert `finish_en` → HOLD, `score=0x0012`. With the macro, `hiscore=0x0012` and `new_record` pulses once. A following crash run at score 3 leaves `hiscore=0x0012`.
- Same-cycle `add_point` edge and `crash_en` edge at score 4 → `score=0x0005`, state HOLD, no bonus. Then `reset_game=1` → `score=0` the next cycle.
- Check the display with score `0x1234`, `show_time=0`: the `an` sequence `1110,1101,1011,0111` with `seg` encoding 4,3,2,1 at 4 cycles per digit and `dp=1`. With `show_time=1`, `dp=0` on digit 1 only.

Source files
------------

// File: rtl/score_keeper.sv
// score_keeper: BCD coin score, tenth-second run timer, optional high score and a
// 4-digit multiplexed seven-segment display driver.
//
// Optional feature: define SCORE_KEEPER_HISCORE_EN to build the high-score register,
// the comparator and the show_hi display select. Without it, hiscore and new_record
// are tied to 0 and show_hi is ignored.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   add_point           coin flag, counted once per rising edge while running
//   reset_game          start-page flag, returns to idle and clears the run
//   pause               stops the run timer
//   crash_en, finish_en end-of-run flags (rising edge), finish adds FINISH_BONUS
//   show_time, show_hi  display select: high score > run timer > score
//   score, run_time     BCD score and BCD timer (tenths of a second)
//   hiscore, new_record BCD high score, one-cycle pulse on a high-score update
//   an, seg, dp         active-low digit enables, segments {g..a}, decimal point
module score_keeper #(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned REFRESH_DIV  = 100_000,
   parameter int unsigned FINISH_BONUS = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        add_point,
   input  logic        reset_game,
   input  logic        pause,
   input  logic        crash_en,
   input  logic        finish_en,
   input  logic        show_time,
   input  logic        show_hi,
   output logic [15:0] score,
   output logic [15:0] run_time,
   output logic [15:0] hiscore,
   output logic        new_record,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam int unsigned TickDiv = (CLK_HZ / 10 > 0) ? CLK_HZ / 10 : 1;
   localparam int unsigned PrescW  = (TickDiv > 1) ? $clog2(TickDiv) : 1;
   localparam int unsigned RefDiv  = (REFRESH_DIV > 0) ? REFRESH_DIV : 1;
   localparam int unsigned RefW    = (RefDiv > 1) ? $clog2(RefDiv) : 1;

   localparam logic [PrescW-1:0] PrescMax = PrescW'(TickDiv - 1);
   localparam logic [RefW-1:0]   RefMax   = RefW'(RefDiv - 1);
   // Bonus converted to BCD at elaboration time
   localparam logic [15:0] BonusBcd = {8'h00, 4'((FINISH_BONUS / 10) % 10),
                                       4'(FINISH_BONUS % 10)};

   typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

   // 4-digit BCD add; any carry out of the top digit saturates to 9999
   function automatic logic [15:0] bcd_add_sat(input logic [15:0] a, input logic [15:0] b);
      logic [15:0] sum;
      logic        carry;
      logic [4:0]  d;
      sum   = '0;
      carry = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'd0, carry};
         if (d > 5'd9) begin
            d     = d - 5'd10;
            carry = 1'b1;
         end else begin
            carry = 1'b0;
         end
         sum[4*i +: 4] = d[3:0];
      end
      return carry ? 16'h9999 : sum;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] nib);
      logic [6:0] on;
      case (nib)
         4'h0: on = 7'h3F;
         4'h1: on = 7'h06;
         4'h2: on = 7'h5B;
         4'h3: on = 7'h4F;
         4'h4: on = 7'h66;
         4'h5: on = 7'h6D;
         4'h6: on = 7'h7D;
         4'h7: on = 7'h07;
         4'h8: on = 7'h7F;
         4'h9: on = 7'h6F;
         4'hA: on = 7'h77;
         4'hB: on = 7'h7C;
         4'hC: on = 7'h39;
         4'hD: on = 7'h5E;
         4'hE: on = 7'h79;
         default: on = 7'h71;
      endcase
      return ~on;
   endfunction

   state_e            state_q, state_d;
   logic [15:0]       score_q, score_d;
   logic [15:0]       time_q, time_d;
   logic [PrescW-1:0] presc_q, presc_d;
   logic              tick_q, tick_d;
   logic              add_point_q, crash_q, finish_q;

   logic              coin_edge, crash_edge, finish_edge;
   logic [15:0]       coin_score, final_score;

   assign coin_edge   = add_point & ~add_point_q;
   assign crash_edge  = crash_en & ~crash_q;
   assign finish_edge = finish_en & ~finish_q;
   assign coin_score  = coin_edge ? bcd_add_sat(score_q, 16'h0001) : score_q;
   assign final_score = bcd_add_sat(coin_score, BonusBcd);

   always_comb begin
      state_d = state_q;
      score_d = score_q;
      time_d  = time_q;
      presc_d = presc_q;
      tick_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            score_d = '0;
            time_d  = '0;
            presc_d = '0;
            if (!reset_game && !pause) state_d = StRun;
         end
         StRun: begin
            score_d = coin_score;
            if (!pause) begin
               if (presc_q == PrescMax) begin
                  presc_d = '0;
                  tick_d  = 1'b1;
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
            // Wrap is registered in tick_q, so the timer moves one cycle later
            if (tick_q) time_d = bcd_add_sat(time_q, 16'h0001);
            // Finish wins over a simultaneous crash; the coin is counted first
            if (finish_edge) begin
               state_d = StHold;
               score_d = final_score;
            end else if (crash_edge) begin
               state_d = StHold;
            end
         end
         StHold: ;
         default: state_d = StIdle;
      endcase
      if (reset_game) begin
         state_d = StIdle;
         score_d = '0;
         time_d  = '0;
         presc_d = '0;
         tick_d  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         score_q     <= '0;
         time_q      <= '0;
         presc_q     <= '0;
         tick_q      <= 1'b0;
         add_point_q <= 1'b0;
         crash_q     <= 1'b0;
         finish_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         score_q     <= score_d;
         time_q      <= time_d;
         presc_q     <= presc_d;
         tick_q      <= tick_d;
         add_point_q <= add_point;
         crash_q     <= crash_en;
         finish_q    <= finish_en;
      end
   end

   assign score    = score_q;
   assign run_time = time_q;

   logic [15:0] disp_val;
   logic        timer_shown;

`ifdef SCORE_KEEPER_HISCORE_EN
   logic [15:0] hi_q;
   logic        rec_q;
   logic        hi_update;

   assign hi_update = (state_q == StRun) && finish_edge && !reset_game && (final_score > hi_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         hi_q  <= '0;
         rec_q <= 1'b0;
      end else begin
         rec_q <= hi_update;
         if (hi_update) hi_q <= final_score;
      end
   end

   assign hiscore     = hi_q;
   assign new_record  = rec_q;
   assign disp_val    = show_hi ? hi_q : (show_time ? time_q : score_q);
   assign timer_shown = show_time & ~show_hi;
`else
   logic unused_show_hi;
   assign unused_show_hi = show_hi;
   assign hiscore        = '0;
   assign new_record     = 1'b0;
   assign disp_val       = show_time ? time_q : score_q;
   assign timer_shown    = show_time;
`endif

   logic [RefW-1:0] refresh_q;
   logic [1:0]      digit_q;
   logic [3:0]      nibble;
   logic [3:0]      an_q;
   logic [6:0]      seg_q;
   logic            dp_q;

   always_comb begin
      nibble = '0;
      case (digit_q)
         2'd0: nibble = disp_val[3:0];
         2'd1: nibble = disp_val[7:4];
         2'd2: nibble = disp_val[11:8];
         default: nibble = disp_val[15:12];
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         refresh_q <= '0;
         digit_q   <= '0;
         an_q      <= 4'b1111;
         seg_q     <= 7'h7F;
         dp_q      <= 1'b1;
      end else begin
         if (refresh_q == RefMax) begin
            refresh_q <= '0;
            digit_q   <= digit_q + 2'd1;
         end else begin
            refresh_q <= refresh_q + 1'b1;
         end
         an_q  <= ~(4'b0001 << digit_q);
         seg_q <= seg_decode(nibble);
         // Decimal point sits between the units and tenths of the timer
         dp_q  <= ~(timer_shown && (digit_q == 2'd1));
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: reset values, coin edge counting, paused timer,
// score saturation, finish bonus, high score, crash/coin collision and the display mux.
module tb_score_keeper;

   logic        clk = 1'b0;
   logic        reset, add_point, reset_game, pause, crash_en, finish_en;
   logic        show_time, show_hi;
   logic [15:0] score, run_time, hiscore;
   logic        new_record;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   int total = 0;
   int bad   = 0;

`ifdef SCORE_KEEPER_HISCORE_EN
   localparam logic [15:0] HiExp  = 16'h0012;
   localparam logic [15:0] RecExp = 16'h0001;
`else
   localparam logic [15:0] HiExp  = 16'h0000;
   localparam logic [15:0] RecExp = 16'h0000;
`endif

   always #5 clk = ~clk;

   score_keeper #(
      .CLK_HZ      (100),
      .REFRESH_DIV (4),
      .FINISH_BONUS(5)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .add_point (add_point),
      .reset_game(reset_game),
      .pause     (pause),
      .crash_en  (crash_en),
      .finish_en (finish_en),
      .show_time (show_time),
      .show_hi   (show_hi),
      .score     (score),
      .run_time  (run_time),
      .hiscore   (hiscore),
      .new_record(new_record),
      .an        (an),
      .seg       (seg),
      .dp        (dp)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic coin(input int n);
      repeat (n) begin
         add_point = 1'b1;
         tick(1);
         add_point = 1'b0;
         tick(1);
      end
   endtask

   // Pulse reset_game, then release it with pause low so the next edge enters RUN
   task automatic new_run();
      reset_game = 1'b1;
      pause      = 1'b0;
      tick(1);
      reset_game = 1'b0;
      tick(1);
   endtask

   // Wait for the first cycle of digit 0 on the display
   task automatic sync_digit0(output logic found);
      logic [3:0] prev;
      found = 1'b0;
      prev  = an;
      for (int i = 0; i < 64 && !found; i++) begin
         tick(1);
         if (an == 4'b1110 && prev != 4'b1110) found = 1'b1;
         else prev = an;
      end
   endtask

   logic [3:0] exp_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [6:0] exp_seg [4] = '{7'h19, 7'h30, 7'h24, 7'h79};  // 4,3,2,1
   logic       found;

   initial begin
      reset = 1'b1; add_point = 1'b0; reset_game = 1'b1; pause = 1'b1;
      crash_en = 1'b0; finish_en = 1'b0; show_time = 1'b0; show_hi = 1'b0;
      tick(3);
      check("rst_score", score, 16'h0000);
      check("rst_time", run_time, 16'h0000);
      check("rst_hi", hiscore, 16'h0000);
      check("rst_rec", 16'(new_record), 16'h0000);
      check("rst_an", 16'(an), 16'h000F);
      check("rst_seg", 16'(seg), 16'h007F);
      check("rst_dp", 16'(dp), 16'h0001);

      // Level held high counts once
      reset = 1'b0; reset_game = 1'b0; pause = 1'b0;
      tick(1);
      add_point = 1'b1;
      tick(50);
      check("held_coin", score, 16'h0001);
      add_point = 1'b0;
      reset_game = 1'b1;
      tick(1);
      check("rg_clear", score, 16'h0000);

      // Coins while paused; paused cycles add no time
      reset_game = 1'b0;
      tick(1);
      pause = 1'b1;
      coin(3);
      tick(19);
      check("pause_time", run_time, 16'h0000);
      pause = 1'b0;
      tick(40);
      pause = 1'b1;
      tick(1);
      check("pause_score", score, 16'h0003);
      check("run_time4", run_time, 16'h0004);

      // Saturation at 9999
      new_run();
      pause = 1'b1;
      coin(9998);
      check("preload", score, 16'h9998);
      coin(3);
      check("sat", score, 16'h9999);

      // Finish with bonus: 7 + 5 = 12
      new_run();
      coin(7);
      check("pre_finish", score, 16'h0007);
      finish_en = 1'b1;
      tick(1);
      check("finish_bonus", score, 16'h0012);
      check("finish_hi", hiscore, HiExp);
      check("rec_pulse", 16'(new_record), RecExp);
      tick(1);
      check("rec_end", 16'(new_record), 16'h0000);
      coin(1);
      check("hold_frozen", score, 16'h0012);
      finish_en = 1'b0;

      // Crash run never updates the high score
      new_run();
      check("hi_keep_rg", hiscore, HiExp);
      coin(3);
      crash_en = 1'b1;
      tick(1);
      check("crash_score", score, 16'h0003);
      check("crash_hi", hiscore, HiExp);
      check("crash_rec", 16'(new_record), 16'h0000);
      crash_en = 1'b0;

      // Coin edge and crash edge together
      new_run();
      coin(4);
      add_point = 1'b1;
      crash_en  = 1'b1;
      tick(1);
      check("coll_score", score, 16'h0005);
      add_point = 1'b0;
      crash_en  = 1'b0;
      tick(1);
      coin(1);
      check("coll_hold", score, 16'h0005);
      reset_game = 1'b1;
      tick(1);
      check("coll_rg", score, 16'h0000);

      // Display with score 1234
      reset_game = 1'b0;
      tick(1);
      pause = 1'b1;
      coin(1234);
      check("disp_score", score, 16'h1234);
      sync_digit0(found);
      check("sync_score", 16'(found), 16'h0001);
      for (int d = 0; d < 4; d++) begin
         check("an_score", 16'(an), 16'(exp_an[d]));
         check("seg_score", 16'(seg), 16'(exp_seg[d]));
         check("dp_score", 16'(dp), 16'h0001);
         tick(4);
      end
      check("an_wrap", 16'(an), 16'h000E);

      // Timer (0.0) shown: decimal point on digit 1 only
      show_time = 1'b1;
      sync_digit0(found);
      check("sync_time", 16'(found), 16'h0001);
      for (int d = 0; d < 4; d++) begin
         check("an_time", 16'(an), 16'(exp_an[d]));
         check("seg_time", 16'(seg), 16'h0040);
         check("dp_time", 16'(dp), (d == 1) ? 16'h0000 : 16'h0001);
         tick(4);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
